// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ requesters with packed valid/ready/addr/data.
// The master modport belongs to the requesters and the slave modport to the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 2,
  parameter int BUS_WIDTH = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ADDR_W-1:0]    req_addr;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with one write stage.
// Optional read-after-write forwarding is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 3,
  parameter int NUM_REQ   = 2,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  req,
  input  logic                 hold,
  input  logic                 err_clr,
  output logic                 err_oob,
  output logic                 we,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [BUS_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  input  logic [BUS_WIDTH-1:0] rf_rd_a,
  input  logic [BUS_WIDTH-1:0] rf_rd_b,
  output logic [BUS_WIDTH-1:0] rd_data_a,
  output logic [BUS_WIDTH-1:0] rd_data_b
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
  logic [BUS_WIDTH-1:0] data_arr [NUM_REQ];

  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;
  logic                 xfer;
  logic                 win_oob;
  logic [ADDR_W-1:0]    win_addr;
  logic [NUM_REQ-1:0]   grant_vec;

  logic                 we_reg;
  logic [ADDR_W-1:0]    wr_addr_reg;
  logic [BUS_WIDTH-1:0] wr_data_reg;
  logic                 err_oob_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req.req_data[gi*BUS_WIDTH +: BUS_WIDTH];
    end
  endgenerate

  // Scan from rr_ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req.req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Gating with rst_n keeps every ready low while reset is held.
  assign xfer     = win_found && !hold && rst_n;
  assign win_addr = addr_arr[win_idx];
  assign win_oob  = int'(win_addr) >= DEPTH;

  always_comb begin
    grant_vec = '0;
    if (xfer) grant_vec[win_idx] = 1'b1;
  end

  assign req.req_ready = grant_vec;
  assign rr_ptr_next   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      we_reg      <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      err_oob_reg <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      if (xfer) begin
        rr_ptr_reg <= rr_ptr_next;
        if (!win_oob) begin
          we_reg      <= 1'b1;
          wr_addr_reg <= win_addr;
          wr_data_reg <= data_arr[win_idx];
        end
      end
      // A new out-of-range acceptance takes priority over a clear.
      if (xfer && win_oob) begin
        err_oob_reg <= 1'b1;
      end else if (err_clr) begin
        err_oob_reg <= 1'b0;
      end
    end
  end

  assign we      = we_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign err_oob = err_oob_reg;

`ifdef REGFILE_WB_BYPASS_EN
  assign rd_data_a = (we_reg && wr_addr_reg == rd_addr_a) ? wr_data_reg : rf_rd_a;
  assign rd_data_b = (we_reg && wr_addr_reg == rd_addr_b) ? wr_data_reg : rf_rd_b;
`else
  assign rd_data_a = rf_rd_a;
  assign rd_data_b = rf_rd_b;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, hand sequences, randomized run vs model.
// A small RAM stands in for register_file so read-path behaviour can be checked.
module tb_regfile_wb_arbiter;
  localparam int BUS_WIDTH = 8;
  localparam int DEPTH     = 3;
  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 2;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       err_clr;
  logic       err_oob;
  logic       we;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic [7:0] rf_rd_a;
  logic [7:0] rf_rd_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;

  int n_tests;
  int n_fail;

  regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .BUS_WIDTH(BUS_WIDTH)) bus ();

  regfile_wb_arbiter #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus), .hold(hold), .err_clr(err_clr),
    .err_oob(err_oob), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in: asynchronous read, write on the clock edge.
  logic [7:0] ram [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ram[i] <= 8'(8'hC0 + i);
    end else if (we) begin
      ram[wr_addr] <= wr_data;
    end
  end
  assign rf_rd_a = ram[rd_addr_a];
  assign rf_rd_b = ram[rd_addr_b];

  // Reference model: priority goes to the requester right after the last one granted.
  function automatic int exp_winner(logic [NUM_REQ-1:0] v, logic h, int last);
    int best;
    int bd;
    best = -1;
    bd   = NUM_REQ;
    if (h) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) begin
        int d;
        d = (i - last - 1 + 2 * NUM_REQ) % NUM_REQ;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  int         m_last;
  int         m_win;
  logic       m_we;
  logic [1:0] m_waddr;
  logic [7:0] m_wdata;
  logic       m_err;
  logic [1:0] m_win_addr;
  logic [7:0] m_win_data;

  always_comb begin
    m_win      = exp_winner(bus.req_valid, hold, m_last);
    m_win_addr = '0;
    m_win_data = '0;
    if (m_win >= 0) begin
      m_win_addr = bus.req_addr[m_win*ADDR_W +: ADDR_W];
      m_win_data = bus.req_data[m_win*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last  <= NUM_REQ - 1;
      m_we    <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
      m_err   <= 1'b0;
    end else begin
      if (m_win >= 0) begin
        m_last <= m_win;
        if (int'(m_win_addr) >= DEPTH) begin
          m_we  <= 1'b0;
          m_err <= 1'b1;
        end else begin
          m_we    <= 1'b1;
          m_waddr <= m_win_addr;
          m_wdata <= m_win_data;
          if (err_clr) m_err <= 1'b0;
        end
      end else begin
        m_we <= 1'b0;
        if (err_clr) m_err <= 1'b0;
      end
    end
  end

  function automatic logic [7:0] exp_rd(logic [1:0] a);
`ifdef REGFILE_WB_BYPASS_EN
    if (m_we && m_waddr == a) return m_wdata;
`endif
    return ram[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] a0, input logic [7:0] d0,
                       input logic [1:0] a1, input logic [7:0] d1);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] a0;
    logic [7:0] d0;
    logic [1:0] a1;
    logic [7:0] d1;
    logic       h;
    logic       clr;
    logic [1:0] rdy;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       err;
    logic       cw;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [1:0] a0, logic [7:0] d0, logic [1:0] a1,
                              logic [7:0] d1, logic h, logic clr, logic [1:0] rdy, logic w,
                              logic [1:0] wa, logic [7:0] wd, logic err, logic cw);
    vec_t r;
    r.v = v; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.h = h; r.clr = clr;
    r.rdy = rdy; r.we = w; r.wa = wa; r.wd = wd; r.err = err; r.cw = cw;
    return r;
  endfunction

  vec_t       tbl [26];
  logic       pend  [NUM_REQ];
  logic [1:0] paddr [NUM_REQ];
  logic [7:0] pdata [NUM_REQ];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // valid a0 d0 a1 d1 hold clr | ready we wa wd err chk_wr
    tbl[0]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b01, 0, 2'd0, 8'h00, 0, 1);
    tbl[1]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b10, 1, 2'd1, 8'h11, 0, 1);
    tbl[2]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b01, 1, 2'd2, 8'h22, 0, 1);
    tbl[3]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b10, 1, 2'd1, 8'h11, 0, 1);
    tbl[4]  = mk(2'b00, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b00, 1, 2'd2, 8'h22, 0, 1);
    tbl[5]  = mk(2'b00, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b00, 0, 2'd2, 8'h22, 0, 1);
    tbl[6]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 1, 0, 2'b00, 0, 2'd2, 8'h22, 0, 1);
    tbl[7]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b01, 0, 2'd2, 8'h22, 0, 1);
    tbl[8]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 1, 0, 2'b00, 1, 2'd1, 8'h11, 0, 1);
    tbl[9]  = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 1, 0, 2'b00, 0, 2'd1, 8'h11, 0, 1);
    tbl[10] = mk(2'b11, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b10, 0, 2'd1, 8'h11, 0, 1);
    tbl[11] = mk(2'b00, 2'd1, 8'h11, 2'd2, 8'h22, 0, 0, 2'b00, 1, 2'd2, 8'h22, 0, 1);
    tbl[12] = mk(2'b01, 2'd3, 8'h33, 2'd2, 8'h22, 0, 0, 2'b01, 0, 2'd2, 8'h22, 0, 1);
    tbl[13] = mk(2'b00, 2'd3, 8'h33, 2'd2, 8'h22, 0, 0, 2'b00, 0, 2'd0, 8'h00, 1, 0);
    tbl[14] = mk(2'b00, 2'd3, 8'h33, 2'd2, 8'h22, 0, 1, 2'b00, 0, 2'd0, 8'h00, 1, 0);
    tbl[15] = mk(2'b00, 2'd3, 8'h33, 2'd2, 8'h22, 0, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0);
    tbl[16] = mk(2'b01, 2'd3, 8'h33, 2'd3, 8'h3C, 0, 0, 2'b01, 0, 2'd0, 8'h00, 0, 0);
    tbl[17] = mk(2'b10, 2'd3, 8'h33, 2'd3, 8'h3C, 0, 1, 2'b10, 0, 2'd0, 8'h00, 1, 0);
    tbl[18] = mk(2'b00, 2'd3, 8'h33, 2'd3, 8'h3C, 0, 0, 2'b00, 0, 2'd0, 8'h00, 1, 0);
    tbl[19] = mk(2'b00, 2'd3, 8'h33, 2'd3, 8'h3C, 0, 1, 2'b00, 0, 2'd0, 8'h00, 1, 0);
    tbl[20] = mk(2'b00, 2'd3, 8'h33, 2'd3, 8'h3C, 0, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0);
    tbl[21] = mk(2'b01, 2'd1, 8'h44, 2'd2, 8'h66, 0, 0, 2'b01, 0, 2'd0, 8'h00, 0, 0);
    tbl[22] = mk(2'b01, 2'd0, 8'h55, 2'd2, 8'h66, 0, 0, 2'b01, 1, 2'd1, 8'h44, 0, 1);
    tbl[23] = mk(2'b11, 2'd1, 8'h77, 2'd2, 8'h66, 0, 0, 2'b10, 1, 2'd0, 8'h55, 0, 1);
    tbl[24] = mk(2'b01, 2'd1, 8'h77, 2'd2, 8'h66, 0, 0, 2'b01, 1, 2'd2, 8'h66, 0, 1);
    tbl[25] = mk(2'b00, 2'd1, 8'h77, 2'd2, 8'h66, 0, 0, 2'b00, 1, 2'd1, 8'h77, 0, 1);

    // Reset state with both requesters asking
    rst_n = 1'b0; hold = 1'b0; err_clr = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    drive(2'b11, 2'd1, 8'h11, 2'd2, 8'h22);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.req_ready), 32'h0);
    chk("reset_we", 32'(we), 32'h0);
    chk("reset_wr_addr", 32'(wr_addr), 32'h0);
    chk("reset_wr_data", 32'(wr_data), 32'h0);
    chk("reset_err", 32'(err_oob), 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].v, tbl[k].a0, tbl[k].d0, tbl[k].a1, tbl[k].d1);
      hold    = tbl[k].h;
      err_clr = tbl[k].clr;
      @(negedge clk);
      $display("[TB] vec %0d valid=%b hold=%b clr=%b ready=%b we=%b addr=%0d data=%h err=%b",
               k, tbl[k].v, hold, err_clr, bus.req_ready, we, wr_addr, wr_data, err_oob);
      chk($sformatf("vec%0d_ready", k), 32'(bus.req_ready), 32'(tbl[k].rdy));
      chk($sformatf("vec%0d_we", k), 32'(we), 32'(tbl[k].we));
      chk($sformatf("vec%0d_err", k), 32'(err_oob), 32'(tbl[k].err));
      if (tbl[k].cw) begin
        chk($sformatf("vec%0d_wr_addr", k), 32'(wr_addr), 32'(tbl[k].wa));
        chk($sformatf("vec%0d_wr_data", k), 32'(wr_data), 32'(tbl[k].wd));
      end
      next_cycle();
    end
    hold = 1'b0; err_clr = 1'b0;

    // Forwarding: write addr2=A5 and read it while it sits in the stage
    drive(2'b01, 2'd2, 8'hA5, 2'd0, 8'h00);
    next_cycle();
    drive(2'b00, 2'd2, 8'hA5, 2'd0, 8'h00);
    rd_addr_a = 2'd2; rd_addr_b = 2'd1;
    @(negedge clk);
    $display("[TB] bypass stage cycle rd_a=%h rd_b=%h", rd_data_a, rd_data_b);
    chk("bypass_we", 32'(we), 32'h1);
`ifdef REGFILE_WB_BYPASS_EN
    chk("bypass_rd_a", 32'(rd_data_a), 32'hA5);
`else
    chk("bypass_rd_a", 32'(rd_data_a), 32'h66);
`endif
    chk("bypass_rd_b", 32'(rd_data_b), 32'h77);
    next_cycle();
    chk("after_write_rd_a", 32'(rd_data_a), 32'hA5);

    // Reset mid-stream with a write in the stage and err_oob set
    drive(2'b01, 2'd3, 8'h01, 2'd0, 8'h00);
    next_cycle();
    drive(2'b01, 2'd1, 8'h12, 2'd2, 8'h34);
    next_cycle();
    chk("pre_reset_we", 32'(we), 32'h1);
    chk("pre_reset_err", 32'(err_oob), 32'h1);
    drive(2'b11, 2'd1, 8'h12, 2'd2, 8'h34);
    rst_n = 1'b0;
    #1;
    chk("midreset_we", 32'(we), 32'h0);
    chk("midreset_err", 32'(err_oob), 32'h0);
    chk("midreset_ready", 32'(bus.req_ready), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();

    // Randomized traffic against the model
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          paddr[i] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          pdata[i] = 8'($urandom);
        end
      end
      drive({pend[1], pend[0]}, paddr[0], pdata[0], paddr[1], pdata[1]);
      hold      = ($urandom_range(0, 7) == 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      rd_addr_a = 2'($urandom_range(0, 2));
      rd_addr_b = 2'($urandom_range(0, 2));
      @(negedge clk);
      chk("rand_ready", 32'(bus.req_ready), (m_win >= 0) ? (32'h1 << m_win) : 32'h0);
      chk("rand_we", 32'(we), 32'(m_we));
      if (m_we) begin
        chk("rand_wr_addr", 32'(wr_addr), 32'(m_waddr));
        chk("rand_wr_data", 32'(wr_data), 32'(m_wdata));
      end
      chk("rand_err", 32'(err_oob), 32'(m_err));
      chk("rand_rd_a", 32'(rd_data_a), 32'(exp_rd(rd_addr_a)));
      chk("rand_rd_b", 32'(rd_data_b), 32'(exp_rd(rd_addr_b)));
      if (m_win >= 0) begin
        $display("[TB] rand %0d grant req%0d addr=%0d data=%h", c, m_win, m_win_addr, m_win_data);
        pend[m_win] = 1'b0;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
